// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch (PC + req/ack memory handshake) and IF/ID register.
// Revision : 1.0
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_INSTRUCTION,
    output logic [31:0] IF_PC_PLUS4,
    output logic        IF_VALID
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] drain_addr, drain_addr_nxt;
    logic [31:0] skid_pc, skid_pc_nxt;
    logic [31:0] skid_instr, skid_instr_nxt;
    logic [31:0] id_pc, id_pc_nxt;
    logic [31:0] id_instr, id_instr_nxt;
    logic [31:0] id_pc4, id_pc4_nxt;
    logic        id_valid, id_valid_nxt;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;

    assign pc_plus4    = pc + 32'd4;
    assign redirect_pc = {BRANCH_TARGET[31:2], 2'b00};

    // While draining, the bus must keep showing the address that is still outstanding.
    assign IMEM_REQ  = (state == S_REQ) || (state == S_DRAIN);
    assign IMEM_ADDR = (state == S_DRAIN) ? drain_addr : pc;

    assign IF_PC          = id_pc;
    assign IF_INSTRUCTION = id_instr;
    assign IF_PC_PLUS4    = id_pc4;
    assign IF_VALID       = id_valid;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        skid_pc_nxt    = skid_pc;
        skid_instr_nxt = skid_instr;
        id_pc_nxt      = id_pc;
        id_instr_nxt   = id_instr;
        id_pc4_nxt     = id_pc4;
        id_valid_nxt   = id_valid;

        if (BRANCH_TAKEN) begin
            id_instr_nxt = NOP_INSTR;
            id_valid_nxt = 1'b0;
            pc_nxt       = redirect_pc;
            case (state)
                S_REQ: begin
                    if (!IMEM_ACK) begin
                        state_nxt      = S_DRAIN;
                        drain_addr_nxt = pc;
                    end
                end
                S_DRAIN: begin
                    if (IMEM_ACK) begin
                        state_nxt = S_REQ;
                    end
                end
                default: state_nxt = S_REQ;
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_REQ;
                end
                S_REQ: begin
                    if (IMEM_ACK) begin
                        if (STALL) begin
                            skid_pc_nxt    = pc;
                            skid_instr_nxt = IMEM_RDATA;
                            state_nxt      = S_HOLD;
                        end else begin
                            id_pc_nxt    = pc;
                            id_instr_nxt = IMEM_RDATA;
                            id_pc4_nxt   = pc_plus4;
                            id_valid_nxt = 1'b1;
                            pc_nxt       = pc_plus4;
                        end
                    end else if (!STALL) begin
                        id_instr_nxt = NOP_INSTR;
                        id_valid_nxt = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!STALL) begin
                        id_pc_nxt    = skid_pc;
                        id_instr_nxt = skid_instr;
                        id_pc4_nxt   = skid_pc + 32'd4;
                        id_valid_nxt = 1'b1;
                        pc_nxt       = pc_plus4;
                        state_nxt    = S_REQ;
                    end
                end
                S_DRAIN: begin
                    id_instr_nxt = NOP_INSTR;
                    id_valid_nxt = 1'b0;
                    if (IMEM_ACK) begin
                        state_nxt = S_REQ;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            drain_addr <= 32'd0;
            skid_pc    <= 32'd0;
            skid_instr <= 32'd0;
            id_pc      <= 32'd0;
            id_instr   <= NOP_INSTR;
            id_pc4     <= 32'd0;
            id_valid   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drain_addr <= drain_addr_nxt;
            skid_pc    <= skid_pc_nxt;
            skid_instr <= skid_instr_nxt;
            id_pc      <= id_pc_nxt;
            id_instr   <= id_instr_nxt;
            id_pc4     <= id_pc4_nxt;
            id_valid   <= id_valid_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Directed self-checking bench for if_stage.
// Revision : 1.0
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] C_NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        if_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hC0DE0001;
    endfunction

    // Memory returns an address-tagged word so each instruction is traceable.
    assign imem_rdata = tag(imem_addr);

    if_stage #(
        .RESET_PC  (32'h00000000),
        .NOP_INSTR (C_NOP)
    ) dut (
        .CLK            (clk),
        .RST            (rst),
        .STALL          (stall),
        .BRANCH_TAKEN   (br_taken),
        .BRANCH_TARGET  (br_target),
        .IMEM_REQ       (imem_req),
        .IMEM_ADDR      (imem_addr),
        .IMEM_ACK       (imem_ack),
        .IMEM_RDATA     (imem_rdata),
        .IF_PC          (if_pc),
        .IF_INSTRUCTION (if_instr),
        .IF_PC_PLUS4    (if_pc4),
        .IF_VALID       (if_valid)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string name, input logic [31:0] pc, input logic [31:0] instr,
                          input logic [31:0] pc4, input logic valid);
        chk({name, ".pc"},    if_pc,    pc);
        chk({name, ".instr"}, if_instr, instr);
        chk({name, ".pc4"},   if_pc4,   pc4);
        chk({name, ".valid"}, {31'd0, if_valid}, {31'd0, valid});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'd0; imem_ack = 1'b0;
        tick(); tick();
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk_if("rst", 32'd0, C_NOP, 32'd0, 1'b0);

        // Reset release: one IDLE cycle, then requests at 0 with ACK tied high.
        rst = 1'b0;
        tick();
        chk("idle.req", {31'd0, imem_req}, 32'd1);
        chk("idle.addr", imem_addr, 32'h0);
        imem_ack = 1'b1;
        tick();
        chk_if("f0", 32'h0, tag(32'h0), 32'h4, 1'b1);
        chk("f0.addr", imem_addr, 32'h4);
        tick();
        chk_if("f4", 32'h4, tag(32'h4), 32'h8, 1'b1);
        chk("f4.addr", imem_addr, 32'h8);

        // Stall coincident with ACK of 0x8 for two cycles.
        stall = 1'b1;
        tick();
        chk_if("hold1", 32'h4, tag(32'h4), 32'h8, 1'b1);
        chk("hold1.req", {31'd0, imem_req}, 32'd0);
        tick();
        chk_if("hold2", 32'h4, tag(32'h4), 32'h8, 1'b1);
        chk("hold2.req", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        tick();
        chk_if("unhold", 32'h8, tag(32'h8), 32'hC, 1'b1);
        chk("unhold.req", {31'd0, imem_req}, 32'd1);
        chk("unhold.addr", imem_addr, 32'hC);

        // Three wait cycles on the fetch of 0xC.
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait.addr", imem_addr, 32'hC);
            chk("wait.req", {31'd0, imem_req}, 32'd1);
            chk_if("wait", 32'h8, C_NOP, 32'hC, 1'b0);
        end
        imem_ack = 1'b1;
        tick();
        chk_if("fC", 32'hC, tag(32'hC), 32'h10, 1'b1);
        chk("fC.addr", imem_addr, 32'h10);

        // Redirect to 0x103 while the fetch of 0x10 is outstanding.
        imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h103;
        tick();
        br_taken = 1'b0;
        chk("drain1.addr", imem_addr, 32'h10);
        chk("drain1.req", {31'd0, imem_req}, 32'd1);
        chk("drain1.valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("drain2.addr", imem_addr, 32'h10);
        chk("drain2.instr", if_instr, C_NOP);
        imem_ack = 1'b1;
        tick();
        chk("drop.valid", {31'd0, if_valid}, 32'd0);
        chk("drop.instr", if_instr, C_NOP);
        chk("drop.addr", imem_addr, 32'h100);
        tick();
        chk_if("f100", 32'h100, tag(32'h100), 32'h104, 1'b1);
        chk("f100.addr", imem_addr, 32'h104);

        // Branch, stall and ACK all in the same cycle.
        br_taken = 1'b1; stall = 1'b1; br_target = 32'h200;
        tick();
        br_taken = 1'b0; stall = 1'b0;
        chk("tri.valid", {31'd0, if_valid}, 32'd0);
        chk("tri.instr", if_instr, C_NOP);
        chk("tri.addr", imem_addr, 32'h200);
        chk("tri.req", {31'd0, imem_req}, 32'd1);
        tick();
        chk_if("f200", 32'h200, tag(32'h200), 32'h204, 1'b1);

        // Wrap-around at the top of the address space; low target bits are masked.
        br_taken = 1'b1; br_target = 32'hFFFFFFFF;
        tick();
        br_taken = 1'b0;
        chk("wrap.addr0", imem_addr, 32'hFFFFFFFC);
        tick();
        chk_if("wrap", 32'hFFFFFFFC, tag(32'hFFFFFFFC), 32'h0, 1'b1);
        chk("wrap.addr1", imem_addr, 32'h0);

        // Reset asserted in the middle of a DRAIN.
        imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h300;
        tick();
        br_taken = 1'b0;
        chk("rd.addr", imem_addr, 32'h0);
        chk("rd.req", {31'd0, imem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.req", {31'd0, imem_req}, 32'd0);
        chk_if("arst", 32'd0, C_NOP, 32'd0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("restart.req", {31'd0, imem_req}, 32'd1);
        chk("restart.addr", imem_addr, 32'h0);
        imem_ack = 1'b1;
        tick();
        chk_if("restart", 32'h0, tag(32'h0), 32'h4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Holds the PC and runs a request/acknowledge fetch from instruction memory.
- Presents registered PC, instruction and PC+4 to the decode stage.
- Handles hazard-unit stalls, branch/jump redirects from EX, and variable-latency memory, including redirects that arrive while a fetch is still outstanding.

Parameters:
RESET_PC  32'h00000000  PC value loaded on reset
NOP_INSTR  32'h00000013  bubble instruction (ADDI x0,x0,0) placed in IF/ID on flush or empty cycle

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
STALL  in  1  hazard unit: hold IF/ID contents and PC
BRANCH_TAKEN  in  1  EX: redirect fetch this cycle
BRANCH_TARGET  in  32  EX: redirect address
IMEM_REQ  out  1  instruction memory read request
IMEM_ADDR  out  32  fetch address, stable while IMEM_REQ=1
IMEM_ACK  in  1  memory: IMEM_RDATA valid this cycle; may be high in the same cycle as the first IMEM_REQ
IMEM_RDATA  in  32  fetched instruction word
IF_PC  out  32  registered PC of instruction in IF/ID
IF_INSTRUCTION  out  32  registered instruction
IF_PC_PLUS4  out  32  registered IF_PC+4
IF_VALID  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, immediate):
  - PC=RESET_PC, state=IDLE, IMEM_REQ=0.
  - IF_PC=0, IF_PC_PLUS4=0, IF_INSTRUCTION=NOP_INSTR, IF_VALID=0.
  - Skid buffer cleared.
- States: IDLE, REQ, HOLD, DRAIN. IMEM_REQ=1 in REQ and DRAIN only. IMEM_ADDR=PC in REQ; latched outstanding address in DRAIN.
- IDLE: one cycle after reset release, then goes to REQ.
- REQ, ACK=1, no redirect, no STALL:
  - IF/ID <= {PC, RDATA, PC+4}, VALID=1.
  - PC <= PC+4; stay REQ.
  - Back-to-back fetch: one instruction per cycle with a zero-wait memory.
- REQ, ACK=1, STALL=1: RDATA and PC go to the skid buffer; IF/ID unchanged; go to HOLD.
- REQ, ACK=0:
  - STALL=1: IF/ID holds.
  - STALL=0: IF/ID <= bubble (NOP_INSTR, VALID=0, PC fields unchanged).
- HOLD:
  - IMEM_REQ=0.
  - When STALL drops: IF/ID <= buffer, VALID=1, PC <= PC+4, go to REQ.
- Redirect (BRANCH_TAKEN=1) has top priority over STALL and ACK:
  - IF/ID <= NOP_INSTR, VALID=0.
  - PC <= {BRANCH_TARGET[31:2],2'b00}.
  - REQ with ACK=1: returned word discarded; stay REQ.
  - REQ with ACK=0: go to DRAIN; request stays asserted at the old address.
  - HOLD: buffer discarded; go to REQ.
  - DRAIN: PC updated; stay DRAIN.
- DRAIN:
  - Held until ACK. The data returned on ACK is always discarded; then go to REQ with the new PC.
  - IF/ID shows bubbles while in DRAIN.
- Request protocol: once asserted, IMEM_REQ and IMEM_ADDR stay constant until the ACK cycle. They never drop or change mid-transaction, including on redirect. Reset is the only exception.
- Arithmetic:
  - PC+4 wraps modulo 2^32 (32'hFFFFFFFC -> 0).
  - BRANCH_TARGET low two bits are forced to 0.
- Latency: an instruction appears on the IF outputs at the clock edge that samples ACK=1 (not stalled).

Test Plan:
- Reset release, ACK tied high, RDATA=addr-tagged words -> IMEM_ADDR 0,4,8,...; IF_PC 0,4,8 on consecutive cycles; IF_VALID=1 from the first ACK edge; IF_PC_PLUS4=IF_PC+4.
- ACK after 3 wait cycles per fetch -> IMEM_ADDR stable during the wait; bubbles (VALID=0, NOP) between instructions; no address skipped.
- STALL=1 for 2 cycles coincident with ACK of addr 0x8 -> IF/ID keeps 0x4; IMEM_REQ=0 in HOLD; after release IF_PC=0x8, then fetch of 0xC.
- BRANCH_TAKEN with target 0x103 while a fetch of 0x10 is waiting (ACK at +2) -> IMEM_ADDR stays 0x10 until ACK; that data is dropped; next IMEM_ADDR=0x100; first valid IF_PC=0x100.
- Simultaneous BRANCH_TAKEN, STALL and ACK -> IF/ID flushed (VALID=0); PC=target; next request at target.
- PC at 0xFFFFFFFC with ACK -> IF_PC_PLUS4=0; next IMEM_ADDR=0.
- RST asserted mid-DRAIN -> outputs immediately at reset values; IMEM_REQ=0; fetch restarts at RESET_PC.
